// File: rtl/vga_pkg.sv
// Shared constants and types for the bar-graph VGA renderer: 640x480 timing,
// palette and the level type.
package vga_pkg;
  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;

  localparam rgb_t BLACK  = 12'h000;
  localparam rgb_t GREEN  = 12'h0F0;
  localparam rgb_t YELLOW = 12'hFF0;
  localparam rgb_t RED    = 12'hF00;
  localparam rgb_t WHITE  = 12'hFFF;

  typedef logic [4:0] level_t;
endpackage

// File: rtl/vga_bar_display_if.sv
// Level write port: valid/ready writes into the shadow bank plus a commit pulse.
interface vga_bar_display_if
  import vga_pkg::*;
#(
  parameter int NUM_BARS = 16,
  parameter int LEVEL_W  = $bits(level_t)
) ();
  localparam int IDX_W = (NUM_BARS > 1) ? $clog2(NUM_BARS) : 1;

  logic               wr_valid;
  logic               wr_ready;
  logic [IDX_W-1:0]   wr_idx;
  logic [LEVEL_W-1:0] wr_level;
  logic               commit;

  modport master (output wr_valid, wr_idx, wr_level, commit, input wr_ready);
  modport slave  (input wr_valid, wr_idx, wr_level, commit, output wr_ready);
endinterface

// File: rtl/vga_timing.sv
// Raster counters, raw syncs, and bar/segment indices tracked by sub-counters
// so the pixel path never divides.
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_ACT    = H_ACTIVE,
  parameter int H_FRONT  = H_FP,
  parameter int H_SW     = H_SYNC,
  parameter int H_BACK   = H_BP,
  parameter int V_ACT    = V_ACTIVE,
  parameter int V_FRONT  = V_FP,
  parameter int V_SW     = V_SYNC,
  parameter int V_BACK   = V_BP,
  parameter int NUM_BARS = 16,
  parameter int LEVELS   = 16,
  localparam int IDX_W   = (NUM_BARS > 1) ? $clog2(NUM_BARS) : 1,
  localparam int SEG_W   = (LEVELS > 1) ? $clog2(LEVELS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  output logic             hsync_raw,
  output logic             vsync_raw,
  output logic             active,
  output logic             frame_origin,
  output logic             swap,
  output logic [IDX_W-1:0] bar_idx,
  output logic [SEG_W-1:0] seg,
  output logic             col_gap,
  output logic             row_gap
);
  localparam int H_TOT = H_ACT + H_FRONT + H_SW + H_BACK;
  localparam int V_TOT = V_ACT + V_FRONT + V_SW + V_BACK;
  localparam int BAR_W = H_ACT / NUM_BARS;
  localparam int SEG_H = V_ACT / LEVELS;
  localparam int HW    = $clog2(H_TOT);
  localparam int VW    = $clog2(V_TOT);
  localparam int CW    = (BAR_W > 1) ? $clog2(BAR_W) : 1;
  localparam int RW    = (SEG_H > 1) ? $clog2(SEG_H) : 1;

  logic [HW-1:0]    h_q, h_d;
  logic [VW-1:0]    v_q, v_d;
  logic [CW-1:0]    col_q, col_d;
  logic [IDX_W-1:0] bar_q, bar_d;
  logic [RW-1:0]    row_q, row_d;
  logic [SEG_W-1:0] segt_q, segt_d;
  logic             line_end, frame_end;

  assign line_end  = (h_q == HW'(H_TOT - 1));
  assign frame_end = line_end && (v_q == VW'(V_TOT - 1));

  always_comb begin
    h_d    = line_end ? '0 : h_q + 1'b1;
    v_d    = v_q;
    col_d  = col_q + 1'b1;
    bar_d  = bar_q;
    row_d  = row_q;
    segt_d = segt_q;
    if (line_end) begin
      v_d   = frame_end ? '0 : v_q + 1'b1;
      col_d = '0;
      bar_d = '0;
    end else if (col_q == CW'(BAR_W - 1)) begin
      col_d = '0;
      // bar index parks on the last bar through horizontal blanking
      if (bar_q != IDX_W'(NUM_BARS - 1)) bar_d = bar_q + 1'b1;
    end
    if (frame_end) begin
      row_d  = '0;
      segt_d = '0;
    end else if (line_end) begin
      if (row_q == RW'(SEG_H - 1)) begin
        row_d = '0;
        if (segt_q != SEG_W'(LEVELS - 1)) segt_d = segt_q + 1'b1;
      end else begin
        row_d = row_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_q    <= '0;
      v_q    <= '0;
      col_q  <= '0;
      bar_q  <= '0;
      row_q  <= '0;
      segt_q <= '0;
    end else begin
      h_q    <= h_d;
      v_q    <= v_d;
      col_q  <= col_d;
      bar_q  <= bar_d;
      row_q  <= row_d;
      segt_q <= segt_d;
    end
  end

  assign hsync_raw    = !((h_q >= HW'(H_ACT + H_FRONT)) && (h_q < HW'(H_ACT + H_FRONT + H_SW)));
  assign vsync_raw    = !((v_q >= VW'(V_ACT + V_FRONT)) && (v_q < VW'(V_ACT + V_FRONT + V_SW)));
  assign active       = (h_q < HW'(H_ACT)) && (v_q < VW'(V_ACT));
  assign frame_origin = (h_q == '0) && (v_q == '0);
  assign swap         = (h_q == '0) && (v_q == VW'(V_ACT));
  assign bar_idx      = bar_q;
  // segment counter runs top-down; flip so segment 0 is the bottom one
  assign seg          = SEG_W'(LEVELS - 1) - segt_q;
  assign col_gap      = (col_q >= CW'(BAR_W - 2));
  assign row_gap      = (row_q == '0);
endmodule

// File: rtl/vga_bar_display.sv
// Bar-graph VGA renderer: double-buffered bar levels, per-bar peak hold with
// decay, colour mux and registered video outputs.
module vga_bar_display
  import vga_pkg::*;
#(
  parameter int NUM_BARS          = 16,
  parameter int LEVELS            = 16,
  parameter int LEVEL_W           = $bits(level_t),
  parameter int PEAK_HOLD_FRAMES  = 30,
  parameter int PEAK_DECAY_FRAMES = 4,
  parameter int H_ACT             = H_ACTIVE,
  parameter int H_FRONT           = H_FP,
  parameter int H_SW              = H_SYNC,
  parameter int H_BACK            = H_BP,
  parameter int V_ACT             = V_ACTIVE,
  parameter int V_FRONT           = V_FP,
  parameter int V_SW              = V_SYNC,
  parameter int V_BACK            = V_BP
) (
  input  logic                clk,
  input  logic                rst,
  vga_bar_display_if.slave    wr,
  output logic                hsync,
  output logic                vsync,
  output logic [3:0]          red,
  output logic [3:0]          green,
  output logic [3:0]          blue,
  output logic                frame_start
);
  localparam int IDX_W   = (NUM_BARS > 1) ? $clog2(NUM_BARS) : 1;
  localparam int SEG_W   = (LEVELS > 1) ? $clog2(LEVELS) : 1;
  localparam int HOLD_W  = $clog2(PEAK_HOLD_FRAMES + 1);
  localparam int PRESC_W = (PEAK_DECAY_FRAMES > 1) ? $clog2(PEAK_DECAY_FRAMES) : 1;
  localparam logic [IDX_W:0] NB_L = (IDX_W + 1)'(NUM_BARS);

  logic             t_hsync, t_vsync, t_active, t_origin, t_swap, t_col_gap, t_row_gap;
  logic [IDX_W-1:0] t_bar;
  logic [SEG_W-1:0] t_seg;

  vga_timing #(
    .H_ACT(H_ACT), .H_FRONT(H_FRONT), .H_SW(H_SW), .H_BACK(H_BACK),
    .V_ACT(V_ACT), .V_FRONT(V_FRONT), .V_SW(V_SW), .V_BACK(V_BACK),
    .NUM_BARS(NUM_BARS), .LEVELS(LEVELS)
  ) u_timing (
    .clk          (clk),
    .rst          (rst),
    .hsync_raw    (t_hsync),
    .vsync_raw    (t_vsync),
    .active       (t_active),
    .frame_origin (t_origin),
    .swap         (t_swap),
    .bar_idx      (t_bar),
    .seg          (t_seg),
    .col_gap      (t_col_gap),
    .row_gap      (t_row_gap)
  );

  logic [NUM_BARS-1:0][LEVEL_W-1:0] shadow_q, shadow_d;
  logic [NUM_BARS-1:0][LEVEL_W-1:0] active_q, active_d;
  logic [NUM_BARS-1:0][LEVEL_W-1:0] peak_q, peak_d;
  logic [NUM_BARS-1:0][HOLD_W-1:0]  hold_q, hold_d;
  logic [PRESC_W-1:0]               presc_q, presc_d;
  logic                             pending_q, pending_d;
  logic                             do_swap, accept, presc_wrap;
  logic [LEVEL_W-1:0]               wr_lvl_c;

  logic                             hsync_q, hsync_d, vsync_q, vsync_d, fs_q, fs_d;
  rgb_t                             rgb_q, rgb_d;
  logic [LEVEL_W-1:0]               lvl, pk, seg_l;

  // the write port stalls only while the shadow bank is being copied
  assign do_swap     = t_swap && pending_q;
  assign wr.wr_ready = !do_swap;
  assign accept      = wr.wr_valid && !do_swap;
  assign wr_lvl_c    = (wr.wr_level > LEVEL_W'(LEVELS)) ? LEVEL_W'(LEVELS) : wr.wr_level;
  assign presc_wrap  = (presc_q == PRESC_W'(PEAK_DECAY_FRAMES - 1));

  always_comb begin
    shadow_d = shadow_q;
    if (accept && ({1'b0, wr.wr_idx} < NB_L)) shadow_d[wr.wr_idx] = wr_lvl_c;
    active_d  = do_swap ? shadow_q : active_q;
    pending_d = (pending_q && !t_swap) || wr.commit;
    presc_d   = presc_q;
    if (t_swap) presc_d = presc_wrap ? '0 : presc_q + 1'b1;
  end

  // peak tracking sees the level that will be displayed next frame
  always_comb begin
    peak_d = peak_q;
    hold_d = hold_q;
    for (int b = 0; b < NUM_BARS; b++) begin
      if (t_swap) begin
        if (active_d[b] >= peak_q[b]) begin
          peak_d[b] = active_d[b];
          hold_d[b] = HOLD_W'(PEAK_HOLD_FRAMES);
        end else if (hold_q[b] != '0) begin
          hold_d[b] = hold_q[b] - 1'b1;
        end else if (presc_wrap) begin
          peak_d[b] = peak_q[b] - 1'b1;
        end
      end
    end
  end

  always_comb begin
    lvl     = active_q[t_bar];
    pk      = peak_q[t_bar];
    seg_l   = LEVEL_W'(t_seg);
    rgb_d   = BLACK;
    if (t_active && !t_col_gap && !t_row_gap) begin
      if ((pk > lvl) && (seg_l + 1'b1 == pk)) begin
        rgb_d = WHITE;
      end else if (seg_l < lvl) begin
        if (seg_l < LEVEL_W'(LEVELS / 2))          rgb_d = GREEN;
        else if (seg_l < LEVEL_W'(3 * LEVELS / 4)) rgb_d = YELLOW;
        else                                       rgb_d = RED;
      end
    end
    hsync_d = t_hsync;
    vsync_d = t_vsync;
    fs_d    = t_origin;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow_q  <= '0;
      active_q  <= '0;
      peak_q    <= '0;
      hold_q    <= '0;
      presc_q   <= '0;
      pending_q <= 1'b0;
      hsync_q   <= 1'b1;
      vsync_q   <= 1'b1;
      fs_q      <= 1'b0;
      rgb_q     <= BLACK;
    end else begin
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      peak_q    <= peak_d;
      hold_q    <= hold_d;
      presc_q   <= presc_d;
      pending_q <= pending_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
      fs_q      <= fs_d;
      rgb_q     <= rgb_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign red         = rgb_q.r;
  assign green       = rgb_q.g;
  assign blue        = rgb_q.b;
  assign frame_start = fs_q;
endmodule

// File: tb/tb_vga_bar_display.sv
// Pixel-exact scoreboard for vga_bar_display on a shrunken raster, with a
// frame-level reference model computed directly from geometry arithmetic.
module tb_vga_bar_display;
  localparam int NB = 3, LV = 8, LW = 4, HOLD = 3, DEC = 2;
  localparam int HA = 24, HF = 2, HS = 3, HB = 3;
  localparam int VA = 24, VF = 1, VS = 2, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int BW = HA / NB;
  localparam int SH = VA / LV;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  vga_bar_display_if #(.NUM_BARS(NB), .LEVEL_W(LW)) wr_if ();
  logic       hsync, vsync, frame_start;
  logic [3:0] red, green, blue;

  vga_bar_display #(
    .NUM_BARS(NB), .LEVELS(LV), .LEVEL_W(LW),
    .PEAK_HOLD_FRAMES(HOLD), .PEAK_DECAY_FRAMES(DEC),
    .H_ACT(HA), .H_FRONT(HF), .H_SW(HS), .H_BACK(HB),
    .V_ACT(VA), .V_FRONT(VF), .V_SW(VS), .V_BACK(VB)
  ) dut (
    .clk(clk), .rst(rst), .wr(wr_if),
    .hsync(hsync), .vsync(vsync), .red(red), .green(green), .blue(blue),
    .frame_start(frame_start)
  );

  typedef struct packed {
    logic rdy; logic hs; logic vs;
    logic [3:0] r; logic [3:0] g; logic [3:0] b;
    logic fs;
  } exp_t;

  localparam exp_t RST_EXP = '{rdy:1'b1, hs:1'b1, vs:1'b1, r:4'h0, g:4'h0, b:4'h0, fs:1'b0};

  exp_t q[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  // reference model state
  int   shadow[NB], active[NB], peak[NB], hold[NB];
  int   presc, h, v;
  bit   pending;
  exp_t prev;

  function automatic void model_reset();
    for (int i = 0; i < NB; i++) begin
      shadow[i] = 0; active[i] = 0; peak[i] = 0; hold[i] = 0;
    end
    presc = 0; h = 0; v = 0; pending = 1'b0;
  endfunction

  function automatic exp_t pix_of();
    exp_t e;
    int   bi, s;
    e    = '0;
    e.hs = !(h >= HA + HF && h < HA + HF + HS);
    e.vs = !(v >= VA + VF && v < VA + VF + VS);
    e.fs = (h == 0 && v == 0);
    if (h < HA && v < VA && (h % BW) < BW - 2 && (v % SH) != 0) begin
      bi = h / BW;
      s  = LV - 1 - v / SH;
      if (peak[bi] > active[bi] && s == peak[bi] - 1) begin
        e.r = 4'hF; e.g = 4'hF; e.b = 4'hF;
      end else if (s < active[bi]) begin
        if (s < LV / 2)          e.g = 4'hF;
        else if (s < 3 * LV / 4) begin e.r = 4'hF; e.g = 4'hF; end
        else                     e.r = 4'hF;
      end
    end
    return e;
  endfunction

  function automatic void model_step(input bit acc, input int idx, input int lvl, input bit cm);
    if (h == 0 && v == VA) begin
      if (pending) for (int i = 0; i < NB; i++) active[i] = shadow[i];
      for (int i = 0; i < NB; i++) begin
        if (active[i] >= peak[i]) begin peak[i] = active[i]; hold[i] = HOLD; end
        else if (hold[i] > 0)     hold[i]--;
        else if (presc == DEC - 1) peak[i]--;
      end
      presc   = (presc + 1) % DEC;
      pending = cm;
    end else begin
      pending = pending | cm;
    end
    if (acc && idx < NB) shadow[idx] = (lvl > LV) ? LV : lvl;
    h = h + 1;
    if (h == HT) begin
      h = 0;
      v = (v + 1) % VT;
    end
  endfunction

  // called just after a rising edge; model holds the state of the current cycle
  task automatic cycle(input bit wv, input int idx, input int lvl, input bit cm);
    exp_t e;
    bit   rdy;
    rdy   = !(h == 0 && v == VA && pending);
    e     = prev;
    e.rdy = rdy;
    q.push_back(e);
    prev  = pix_of();
    wr_if.wr_valid = wv;
    wr_if.wr_idx   = idx[1:0];
    wr_if.wr_level = lvl[3:0];
    wr_if.commit   = cm;
    @(posedge clk); #1;
    model_step(wv && rdy, idx, lvl, cm);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 0, 0, 1'b0);
  endtask

  task automatic run_to(input int hh, input int vv);
    int k;
    k = 0;
    while (!(h == hh && v == vv) && k <= HT * VT) begin
      cycle(1'b0, 0, 0, 1'b0);
      k++;
    end
    n_assert++;
    if (!(h == hh && v == vv)) begin
      n_fail++;
      $display("FAIL run_to: reached h=%0d v=%0d, required h=%0d v=%0d", h, v, hh, vv);
    end
  endtask

  task automatic apply_reset(input int ncyc);
    rst = 1'b0;
    wr_if.wr_valid = 1'b0; wr_if.commit = 1'b0; wr_if.wr_idx = '0; wr_if.wr_level = '0;
    model_reset();
    prev = RST_EXP;
    q.push_back(RST_EXP);
    repeat (ncyc) begin
      @(posedge clk); #1;
      q.push_back(RST_EXP);
    end
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  always @(negedge clk) begin : monitor
    exp_t e, a;
    if (q.size() > 0) begin
      e     = q.pop_front();
      a.rdy = wr_if.wr_ready; a.hs = hsync; a.vs = vsync;
      a.r   = red; a.g = green; a.b = blue; a.fs = frame_start;
      n_assert++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL pix_cycle t=%0t got rdy=%b hs=%b vs=%b rgb=%h%h%h fs=%b, want rdy=%b hs=%b vs=%b rgb=%h%h%h fs=%b",
                 $time, a.rdy, a.hs, a.vs, a.r, a.g, a.b, a.fs,
                 e.rdy, e.hs, e.vs, e.r, e.g, e.b, e.fs);
      end
    end
  end

  initial begin
    wr_if.wr_valid = 1'b0; wr_if.commit = 1'b0; wr_if.wr_idx = '0; wr_if.wr_level = '0;
    model_reset();
    prev = RST_EXP;
    @(posedge clk); #1;
    apply_reset(3);

    // first frame dark, syncs and frame_start positions
    idle(HT * VT);

    // mid-frame commit of bar 1 shows only from the next frame
    cycle(1'b1, 1, 5, 1'b0);
    run_to(0, 5);
    cycle(1'b0, 0, 0, 1'b1);
    idle(2 * HT * VT);

    // over-range level clamps to full height
    cycle(1'b1, 0, 15, 1'b1);
    idle(2 * HT * VT);

    // peak hold and decay on bar 2
    cycle(1'b1, 2, 7, 1'b1);
    run_to(0, VA + 1);
    cycle(1'b1, 2, 2, 1'b1);
    idle((HOLD + DEC * 6 + 2) * HT * VT);

    // write held through a pending swap, plus a commit in the swap cycle
    cycle(1'b1, 1, 3, 1'b1);
    run_to(HT - 3, VA - 1);
    for (int i = 0; i < 6; i++) cycle(1'b1, 1, 6, (h == 0 && v == VA));
    idle(2 * HT * VT);

    // randomized writes (including dropped indices) and commits
    for (int i = 0; i < 15 * HT * VT; i++) begin
      bit cm, wv;
      cm = ($urandom_range(0, 299) == 0) || (h == 0 && v == VA && $urandom_range(0, 3) == 0);
      wv = ($urandom_range(0, 39) == 0);
      cycle(wv, int'($urandom_range(0, 3)), int'($urandom_range(0, 15)), cm);
    end

    // asynchronous reset in the middle of a frame
    run_to(10, 12);
    apply_reset(2);
    idle(2 * HT * VT);

    @(negedge clk); #1;
    n_assert++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain: %0d entries left, required 0", q.size());
    end
    n_assert++;
    if (n_assert < 1000) begin
      n_fail++;
      $display("FAIL check_count: %0d comparisons, required at least 1000", n_assert);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
